serial_master_port: RTL

//  Bus-master end of the serial bus: takes a parallel transaction request from local logic.

---
 rtl/serial_master_port.sv | 307 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/serial_master_port.sv
// -----------------------------------------------------------------------------
// serial_master_port
//
// Bus-master end of the serial bus. Accepts a parallel transaction request
// from the local master core, serialises an 18-bit (default) config frame on
// `control`, then either streams write words out on `wD` or collects read
// words from `rD`. Read sampling is paced by the slave's `ready`.
//
// Frame layout, sent MSB first:
//   {3'b111, slave_sel, rw, B, addr}   with B = (burst_len != 0)
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   start                  request pulse, only looked at while idle
//   rw                     0 = read, 1 = write
//   slave_sel, addr        target slave and start address
//   burst_len              number of words minus one
//   wr_data/wr_valid       write word offered by the core
//   wr_ready               core's word is taken when wr_valid & wr_ready
//   rd_data/rd_valid       received read word, rd_valid is a 1-cycle pulse
//   busy                   a transaction is in progress
//   done / error           1-cycle pulses: normal end / ready timeout abort
//   control                serial config frame
//   wD / valid             serial write data and its qualifier
//   last                   final-word marker
//   rD / ready             serial read data and slave pacing
// -----------------------------------------------------------------------------
module serial_master_port #(
    parameter int ADDR_DEPTH = 2000,
    parameter int SLAVES     = 3,
    parameter int DATA_WIDTH = 32,
    parameter int SLAVEID    = $clog2(SLAVES),
    parameter int LEN_WIDTH  = 8,
    parameter int TIMEOUT    = 255,
    parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  rw,
    input  logic [SLAVEID-1:0]    slave_sel,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  control,
    output logic                  wD,
    output logic                  valid,
    output logic                  last,
    input  logic                  rD,
    input  logic                  ready
);

    localparam int FRAME_W = 5 + SLAVEID + ADDR_WIDTH;
    // One counter serves the frame (bits sent), WR (bits left) and RD (bits taken).
    localparam int MAX_BITS = (FRAME_W > DATA_WIDTH) ? FRAME_W : DATA_WIDTH;
    localparam int BIT_W    = $clog2(MAX_BITS + 1);
    localparam int TIMER_W  = $clog2(TIMEOUT + 1);
    // One extra bit so that N = 2**LEN_WIDTH words fits without wrapping.
    localparam int WORD_W   = LEN_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_WAIT,
        S_WR,
        S_RD,
        S_FIN
    } state_e;

    state_e                state_q, state_d;
    logic                  rw_q, rw_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [FRAME_W-1:0]    frame_q, frame_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]     word_cnt_q, word_cnt_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic                  seen_low_q, seen_low_d;

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  control_q, control_d;
    logic                  wd_q, wd_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    logic [FRAME_W-1:0]    frame_new;
    logic [WORD_W-1:0]     n_words;
    logic [WORD_W-1:0]     words_next;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  timer_expired;

    assign frame_new     = {3'b111, slave_sel, rw, burst_len != '0, addr};
    assign n_words       = {1'b0, len_q} + WORD_W'(1);
    assign words_next    = word_cnt_q + WORD_W'(1);
    assign rd_word       = {shift_q[DATA_WIDTH-2:0], rD};
    assign timer_expired = (timer_q == TIMER_W'(TIMEOUT - 1));

    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch;
        // pulses and serial qualifiers default low, state registers hold.
        state_d    = state_q;
        rw_d       = rw_q;
        len_d      = len_q;
        frame_d    = frame_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        timer_d    = timer_q;
        seen_low_d = seen_low_q;
        busy_d     = busy_q;
        rd_data_d  = rd_data_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        control_d  = 1'b0;
        wd_d       = 1'b0;
        valid_d    = 1'b0;
        last_d     = 1'b0;
        rd_valid_d = 1'b0;
        wr_ready   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rw_d       = rw;
                    len_d      = burst_len;
                    // MSB goes straight onto control; the register keeps the rest.
                    control_d  = frame_new[FRAME_W-1];
                    frame_d    = frame_new << 1;
                    bit_cnt_d  = BIT_W'(1);
                    word_cnt_d = '0;
                    timer_d    = '0;
                    seen_low_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_CFG;
                end
            end

            S_CFG: begin
                if (bit_cnt_q == BIT_W'(FRAME_W)) begin
                    bit_cnt_d  = '0;
                    timer_d    = '0;
                    seen_low_d = 1'b0;
                    state_d    = S_WAIT;
                end else begin
                    control_d = frame_q[FRAME_W-1];
                    frame_d   = frame_q << 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end

            S_WAIT: begin
                if (ready) begin
                    timer_d = '0;
                    if (rw_q) begin
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                        state_d    = S_WR;
                    end else if (seen_low_q) begin
                        // Slave has turned the bus around: ready went low, then high.
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                        last_d     = (len_q == '0);
                        state_d    = S_RD;
                    end
                end else begin
                    seen_low_d = 1'b1;
                    if (timer_expired) begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
            end

            S_WR: begin
                if (bit_cnt_q != '0) begin
                    // Mid-word: keep shifting, one bit per cycle with no gaps.
                    wd_d      = shift_q[DATA_WIDTH-1];
                    shift_d   = shift_q << 1;
                    valid_d   = 1'b1;
                    bit_cnt_d = bit_cnt_q - BIT_W'(1);
                    last_d    = (bit_cnt_q == BIT_W'(1)) && (word_cnt_q == n_words);
                end else if (word_cnt_q == n_words) begin
                    state_d = S_FIN;
                end else begin
                    // Word boundary: fetch the next word or idle the line (no timeout).
                    wr_ready = 1'b1;
                    if (wr_valid) begin
                        wd_d       = wr_data[DATA_WIDTH-1];
                        shift_d    = wr_data << 1;
                        valid_d    = 1'b1;
                        bit_cnt_d  = BIT_W'(DATA_WIDTH - 1);
                        word_cnt_d = words_next;
                        last_d     = (DATA_WIDTH == 1) && (words_next == n_words);
                    end
                end
            end

            S_RD: begin
                if (ready) begin
                    timer_d = '0;
                    shift_d = rd_word;
                    if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                        rd_data_d  = rd_word;
                        rd_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        word_cnt_d = words_next;
                        // Flag the slave one word early so it can close the burst.
                        last_d     = (words_next == n_words - WORD_W'(1));
                        if (words_next == n_words) begin
                            state_d = S_FIN;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else if (timer_expired) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: datapath registers are reset along with control so that every
    // output, including rd_data, reads 0 straight after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            rw_q       <= 1'b0;
            len_q      <= '0;
            frame_q    <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            timer_q    <= '0;
            seen_low_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            control_q  <= 1'b0;
            wd_q       <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from the
            // same pre-edge values, independent of statement order.
            state_q    <= state_d;
            rw_q       <= rw_d;
            len_q      <= len_d;
            frame_q    <= frame_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            timer_q    <= timer_d;
            seen_low_q <= seen_low_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            control_q  <= control_d;
            wd_q       <= wd_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign control  = control_q;
    assign wD       = wd_q;
    assign valid    = valid_q;
    assign last     = last_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule
